// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
//   Shared definitions for the single-clock FIFO slice:
//   - default DATASIZE / ADDRSIZE
//   - helpers that derive depth and pointer width from ADDRSIZE
//   - ptr_t / cnt_t sized for the default configuration
//   - error-code enum used by scoreboards to classify rejected operations
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int DEF_DATASIZE = 8;
  localparam int DEF_ADDRSIZE = 4;

  // Number of words addressed by ADDRSIZE bits.
  function automatic int depth_of(input int addrsize);
    return 1 << addrsize;
  endfunction

  // Pointers carry one extra wrap bit above the RAM index.
  function automatic int ptr_width(input int addrsize);
    return addrsize + 1;
  endfunction

  localparam int DEPTH = depth_of(DEF_ADDRSIZE);

  typedef logic [ptr_width(DEF_ADDRSIZE)-1:0] ptr_t;
  typedef logic [ptr_width(DEF_ADDRSIZE)-1:0] cnt_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_OVF,
    ERR_UDF
  } err_e;

endpackage

// File: rtl/sync_fifo_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_if
//   Handshake and status bundle between a FIFO user (master) and the FIFO
//   controller (slave). clk/rst_n are not part of the bundle.
//   master drives : clr, winc, wdata, rinc
//   slave drives  : rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty,
//                   count, overflow, underflow
// -----------------------------------------------------------------------------
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DATASIZE = DEF_DATASIZE,
  parameter int ADDRSIZE = DEF_ADDRSIZE
);

  logic                clr;
  logic                winc;
  logic [DATASIZE-1:0] wdata;
  logic                rinc;
  logic [DATASIZE-1:0] rdata;
  logic                rvalid;
  logic                wfull;
  logic                rempty;
  logic                walmost_full;
  logic                ralmost_empty;
  logic [ADDRSIZE:0]   count;
  logic                overflow;
  logic                underflow;

  modport master (
    output clr, winc, wdata, rinc,
    input  rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clr, winc, wdata, rinc,
    output rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// -----------------------------------------------------------------------------
// sync_fifo_ram
//   1W/1R storage: synchronous write, asynchronous (combinational) read.
//   Ports: clk, we, waddr, wdata (write side); raddr -> rdata (read side).
// -----------------------------------------------------------------------------
module sync_fifo_ram #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);

  logic [DATASIZE-1:0] mem [1 << ADDRSIZE];

  // NOTE: storage arrays carry no reset; validity is tracked by the pointers,
  // so contents never need clearing and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctl
//   Single-clock FIFO controller: binary wrap-bit pointers, occupancy count,
//   almost-full / almost-empty thresholds, sticky overflow / underflow errors
//   and a synchronous flush (clr). Storage lives in sync_fifo_ram.
//   Ports: clk, rst_n (async, active-low), bus (sync_fifo_if.slave).
//   Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
//   (rdata shows the head word combinationally); otherwise reads are
//   registered with one cycle latency and rdata holds its last value.
// -----------------------------------------------------------------------------
module sync_fifo_ctl
  import sync_fifo_pkg::*;
#(
  parameter int DATASIZE      = DEF_DATASIZE,
  parameter int ADDRSIZE      = DEF_ADDRSIZE,
  parameter int AFULL_MARGIN  = 2,
  parameter int AEMPTY_MARGIN = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  sync_fifo_if.slave   bus
);

  localparam int              PW         = ptr_width(ADDRSIZE);
  localparam int              FIFO_DEPTH = depth_of(ADDRSIZE);
  localparam logic [PW-1:0]   AFULL_LVL  = PW'(FIFO_DEPTH - AFULL_MARGIN);
  localparam logic [PW-1:0]   AEMPTY_LVL = PW'(AEMPTY_MARGIN);
  localparam logic [PW-1:0]   PTR_ONE    = PW'(1);

  logic [PW-1:0]       wptr_q, wptr_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;
  logic [PW-1:0]       count;
  logic                wfull, rempty;
  logic                wr_acc, rd_acc;
  logic [DATASIZE-1:0] ram_rdata;

  // Flags decode the registered pointers only.
  assign count  = wptr_q - rptr_q;
  assign rempty = (wptr_q == rptr_q);
  assign wfull  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                  (wptr_q[PW-2:0] == rptr_q[PW-2:0]);

  // A flush swallows any request issued in the same cycle.
  assign wr_acc = bus.winc && !wfull  && !bus.clr;
  assign rd_acc = bus.rinc && !rempty && !bus.clr;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (bus.clr) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
    end else begin
      if (wr_acc)              wptr_d = wptr_q + PTR_ONE;
      if (rd_acc)              rptr_d = rptr_q + PTR_ONE;
      if (bus.winc && wfull)   ovf_d  = 1'b1;
      if (bus.rinc && rempty)  udf_d  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  sync_fifo_ram #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr_q[ADDRSIZE-1:0]),
    .wdata (bus.wdata),
    .raddr (rptr_q[ADDRSIZE-1:0]),
    .rdata (ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is shown while the FIFO is non-empty; rinc consumes it.
  assign bus.rdata  = rempty ? '0 : ram_rdata;
  assign bus.rvalid = !rempty;
`else
  logic [DATASIZE-1:0] rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rd_acc;
    if (rd_acc)  rdata_d = ram_rdata;
    if (bus.clr) rdata_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
`endif

  assign bus.wfull         = wfull;
  assign bus.rempty        = rempty;
  assign bus.count         = count;
  assign bus.walmost_full  = (count >= AFULL_LVL);
  assign bus.ralmost_empty = (count <= AEMPTY_LVL);
  assign bus.overflow      = ovf_q;
  assign bus.underflow     = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_ctl
//   Self-checking bench for sync_fifo_ctl (DATASIZE=8, ADDRSIZE=4, margins=2).
//   A queue-based reference model predicts every output after each clock;
//   a vector table and hand-written sequences add fixed expectations.
//   Works in both read modes (SYNC_FIFO_FWFT_EN defined or not).
// -----------------------------------------------------------------------------
module tb_sync_fifo_ctl;
  import sync_fifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH_TB = 16;

  logic clk;
  logic rst_n;

  sync_fifo_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();

  sync_fifo_ctl #(
    .DATASIZE      (DW),
    .ADDRSIZE      (AW),
    .AFULL_MARGIN  (2),
    .AEMPTY_MARGIN (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  logic [DW-1:0] q [$];
  logic          m_ovf, m_udf, m_rvalid;
  logic [DW-1:0] m_rdata;

  task automatic model_reset();
    q.delete();
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
  endtask

  task automatic model_clock(input logic w, input logic [DW-1:0] d,
                             input logic r, input logic c);
    int   n;
    err_e e;
    if (c) begin
      model_reset();
    end else begin
      n = q.size();
      e = ERR_NONE;
      m_rvalid = 1'b0;
      if (r) begin
        if (n > 0) begin
          m_rdata  = q.pop_front();
          m_rvalid = 1'b1;
        end else begin
          e = ERR_UDF;
        end
      end
      if (w) begin
        if (n < DEPTH_TB) q.push_back(d);
        else              e = ERR_OVF;
      end
      if (e == ERR_OVF) m_ovf = 1'b1;
      if (e == ERR_UDF) m_udf = 1'b1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    check("count",         bus.count,         n);
    check("rempty",        bus.rempty,        n == 0);
    check("wfull",         bus.wfull,         n == DEPTH_TB);
    check("walmost_full",  bus.walmost_full,  n >= DEPTH_TB - 2);
    check("ralmost_empty", bus.ralmost_empty, n <= 2);
    check("overflow",      bus.overflow,      m_ovf);
    check("underflow",     bus.underflow,     m_udf);
`ifdef SYNC_FIFO_FWFT_EN
    check("rvalid",        bus.rvalid,        n > 0);
    check("rdata",         bus.rdata,         (n > 0) ? q[0] : 8'h00);
`else
    check("rvalid",        bus.rvalid,        m_rvalid);
    check("rdata",         bus.rdata,         m_rdata);
`endif
  endtask

  // Called 1 time unit after a posedge: drive inputs, take one clock,
  // advance the model and compare everything.
  task automatic step(input logic w, input logic [DW-1:0] d,
                      input logic r, input logic c);
    bus.winc  = w;
    bus.wdata = d;
    bus.rinc  = r;
    bus.clr   = c;
    @(posedge clk);
    model_clock(w, d, r, c);
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    bus.winc  = 1'b0;
    bus.wdata = '0;
    bus.rinc  = 1'b0;
    bus.clr   = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          winc;
    logic [DW-1:0] wdata;
    logic          rinc;
    logic          clr;
    int            exp_count;
    logic          exp_ovf;
    logic          exp_udf;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0};  // idle after reset
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1};  // pop empty
    vecs[2] = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'h33, 1'b1, 1'b0, 2, 1'b0, 1'b1};  // push+pop
    vecs[5] = '{1'b1, 8'h77, 1'b0, 1'b1, 0, 1'b0, 1'b0};  // clr beats winc
    vecs[6] = '{1'b1, 8'h44, 1'b1, 1'b0, 1, 1'b0, 1'b1};  // empty: write only
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0};  // clr clears errors

    model_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count",   bus.count,         0);
    check("rst_rempty",  bus.rempty,        1);
    check("rst_wfull",   bus.wfull,         0);
    check("rst_ralmost", bus.ralmost_empty, 1);
    check("rst_walmost", bus.walmost_full,  0);
    check("rst_ovf",     bus.overflow,      0);
    check("rst_udf",     bus.underflow,     0);
`ifndef SYNC_FIFO_FWFT_EN
    check("rst_rvalid",  bus.rvalid,        0);
    check("rst_rdata",   bus.rdata,         0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].winc, vecs[i].wdata, vecs[i].rinc, vecs[i].clr);
      check($sformatf("vec%0d_count", i),  bus.count,     vecs[i].exp_count);
      check($sformatf("vec%0d_rempty", i), bus.rempty,    vecs[i].exp_count == 0);
      check($sformatf("vec%0d_ovf", i),    bus.overflow,  vecs[i].exp_ovf);
      check($sformatf("vec%0d_udf", i),    bus.underflow, vecs[i].exp_udf);
    end

    // 1: fill 0x00..0x0F, then drain in order
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      check("t1_walmost", bus.walmost_full, (i + 1) >= 14);
      check("t1_wfull",   bus.wfull,        (i + 1) == 16);
    end
    check("t1_count_full", bus.count, 16);
    for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check("t1_head", bus.rdata, i);
`endif
      step(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
      check("t1_rdata",  bus.rdata,  i);
      check("t1_rvalid", bus.rvalid, 1);
`endif
    end
    check("t1_rempty", bus.rempty, 1);

    // 2: simultaneous ops at full and at empty
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    check("t2_ovf",   bus.overflow, 1);
    check("t2_count", bus.count,    15);
    for (int i = 1; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check("t2_head", bus.rdata, 8'h80 + i);
`endif
      step(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
      check("t2_rdata", bus.rdata, 8'h80 + i);
`endif
    end
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("t2_udf",    bus.underflow, 1);
    check("t2_count1", bus.count,     1);
`ifdef SYNC_FIFO_FWFT_EN
    check("t2_head55", bus.rdata, 8'h55);
`endif
    step(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
    check("t2_rdata55", bus.rdata, 8'h55);
`endif
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // 3: steady push+pop at count 5 for 100 cycles
    for (int i = 0; i < 5; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    for (int k = 0; k < 100; k++) begin
      step(1'b1, 8'(k + 5), 1'b1, 1'b0);
      check("t3_count", bus.count, 5);
`ifndef SYNC_FIFO_FWFT_EN
      check("t3_rdata", bus.rdata, 8'(k));
`endif
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // 4: clr at count 9 with winc, errors pre-set
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    check("t4_udf_before", bus.underflow, 1);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    check("t4_count",  bus.count,     0);
    check("t4_rempty", bus.rempty,    1);
    check("t4_udf",    bus.underflow, 0);
    check("t4_ovf",    bus.overflow,  0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t4_not_stored", bus.underflow, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // 5: asynchronous reset mid-burst at count 7
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
    step(1'b1, 8'hD8, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t5_count7", bus.count, 7);
    bus.winc  = 1'b1;
    bus.wdata = 8'h99;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t5_async_count",  bus.count,    0);
    check("t5_async_rempty", bus.rempty,   1);
    check("t5_async_rvalid", bus.rvalid,   0);
    check("t5_async_rdata",  bus.rdata,    0);
    check_model();
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t5_udf",    bus.underflow, 1);
    check("t5_rvalid", bus.rvalid,    0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

`ifdef SYNC_FIFO_FWFT_EN
    // 6: first-word-fall-through
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    check("t6_rdata",  bus.rdata,  8'h3C);
    check("t6_rvalid", bus.rvalid, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t6_rempty", bus.rempty, 1);
    check("t6_rdata0", bus.rdata,  0);
`endif

    // Randomized traffic: write-biased then read-biased, rare flushes
    for (int k = 0; k < 600; k++) begin
      logic w, r, c;
      if (k < 300) begin
        w = ($urandom_range(99) < 70);
        r = ($urandom_range(99) < 40);
      end else begin
        w = ($urandom_range(99) < 40);
        r = ($urandom_range(99) < 70);
      end
      c = ($urandom_range(63) == 0);
      step(w, 8'($urandom), r, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
